// File: rtl/ibuf_load_ctrl.sv
// ibuf_load_ctrl: task-level sequencer for the index-buffer load path.
// Accepts one load task (base address, group stride, index count, mode, group mask).
// For each enabled PE group, in order, it issues one DDR read command and starts
// ddr2ibuf with that group's PE mask. It then counts index writes to detect the end
// of the group. It also generates the task-level done pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/done/busy     task handshake (start ignored while busy)
//   cfg_*               task configuration, latched on an accepted start
//   rd_cmd_*            DDR read-command channel (valid/ready)
//   ib_start, ib_conf_* ddr2ibuf control
//   ib_wr_en            monitored copy of ddr2ibuf idx_wr_en
module ibuf_load_ctrl #(
    parameter int unsigned PE_NUM    = 32,
    parameter int unsigned GRP_NUM   = 4,
    parameter int unsigned DDR_W     = 512,
    parameter int unsigned IDX_W     = 16,
    parameter int unsigned IDX_BATCH = DDR_W / IDX_W / 2,
    parameter int unsigned DADDR_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               done,
    output logic               busy,
    input  logic [DADDR_W-1:0] cfg_base_addr,
    input  logic [DADDR_W-1:0] cfg_grp_stride,
    input  logic [7:0]         cfg_idx_num,
    input  logic [3:0]         cfg_mode,
    input  logic [GRP_NUM-1:0] cfg_grp_mask,
    output logic [DADDR_W-1:0] rd_cmd_addr,
    output logic [7:0]         rd_cmd_len,
    output logic               rd_cmd_valid,
    input  logic               rd_cmd_ready,
    output logic               ib_start,
    output logic [3:0]         ib_conf_mode,
    output logic [7:0]         ib_conf_idx_num,
    output logic [PE_NUM-1:0]  ib_conf_mask,
    input  logic [PE_NUM-1:0]  ib_wr_en
);

    localparam int unsigned PE_PER_GRP = PE_NUM / GRP_NUM;
    localparam int unsigned GW         = $clog2(GRP_NUM + 1);
    localparam int unsigned MW         = 1 << GW;

    typedef enum logic [2:0] {StIdle, StScan, StCmd, StLoad, StDone} state_e;

    state_e             state_q;
    logic [GW-1:0]      g_q;
    logic [DADDR_W-1:0] ga_q;
    logic [7:0]         wcnt_q;
    logic               ib_start_q;
    logic [DADDR_W-1:0] stride_q;
    logic [7:0]         idx_num_q;
    logic [3:0]         mode_q;
    logic [GRP_NUM-1:0] grp_mask_q;

    logic               wr_hit;
    logic [7:0]         wcnt_inc;
    logic               grp_last;
    logic [8:0]         len_sum;
    logic [7:0]         cmd_len;
    logic [MW-1:0]      mask_ext;
    logic               grp_act;

    // Zero-extended so that indexing with g == GRP_NUM stays in range.
    assign mask_ext = {{(MW - GRP_NUM){1'b0}}, grp_mask_q};
    assign wr_hit   = |ib_wr_en;
    assign wcnt_inc = wcnt_q + 8'(wr_hit);
    // Group completes when the count reaches idx_num, counting a write landing now.
    assign grp_last = (wcnt_inc == idx_num_q) || (wcnt_q == idx_num_q);
    assign len_sum  = {1'b0, idx_num_q} + 9'(IDX_BATCH - 1);
    assign cmd_len  = 8'(len_sum / 9'(IDX_BATCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            g_q        <= '0;
            ga_q       <= '0;
            wcnt_q     <= '0;
            ib_start_q <= 1'b0;
            stride_q   <= '0;
            idx_num_q  <= '0;
            mode_q     <= '0;
            grp_mask_q <= '0;
        end else begin
            ib_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        stride_q   <= cfg_grp_stride;
                        idx_num_q  <= cfg_idx_num;
                        mode_q     <= cfg_mode;
                        grp_mask_q <= cfg_grp_mask;
                        g_q        <= '0;
                        ga_q       <= cfg_base_addr;
                        state_q    <= (cfg_idx_num == 8'd0) ? StDone : StScan;
                    end
                end
                StScan: begin
                    if (g_q == GW'(GRP_NUM)) begin
                        state_q <= StDone;
                    end else if (mask_ext[g_q]) begin
                        state_q    <= StCmd;
                        ib_start_q <= 1'b1;
                        wcnt_q     <= '0;
                    end else begin
                        g_q  <= g_q + GW'(1);
                        ga_q <= ga_q + stride_q;
                    end
                end
                StCmd: begin
                    wcnt_q <= wcnt_inc;
                    if (rd_cmd_ready) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    wcnt_q <= wcnt_inc;
                    if (grp_last) begin
                        g_q     <= g_q + GW'(1);
                        ga_q    <= ga_q + stride_q;
                        state_q <= StScan;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        grp_act         = (state_q == StCmd) || (state_q == StLoad);
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        rd_cmd_valid    = (state_q == StCmd);
        rd_cmd_addr     = rd_cmd_valid ? ga_q : '0;
        rd_cmd_len      = rd_cmd_valid ? cmd_len : '0;
        ib_start        = ib_start_q;
        ib_conf_mode    = busy ? mode_q : '0;
        ib_conf_idx_num = busy ? idx_num_q : '0;
        ib_conf_mask    = '0;
        for (int i = 0; i < int'(PE_NUM); i++) begin
            ib_conf_mask[i] = grp_act && ((i / int'(PE_PER_GRP)) == int'(g_q));
        end
    end

endmodule
